// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures the high time and the rising-to-rising period of an
// asynchronous PWM input, flags out-of-range pulses and reports loss of signal.
module servo_pwm_capture #(
  parameter int MIN_PULSE = 50_000,
  parameter int MAX_PULSE = 250_000,
  parameter int TIMEOUT   = 2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [17:0] pulse_len,
  output logic [21:0] period_len,
  output logic        valid,
  output logic        pulse_err,
  output logic        signal_lost
);

  localparam int          SIL_W = $clog2(TIMEOUT + 1);
  localparam logic [17:0] MIN_L = 18'(MIN_PULSE);
  localparam logic [17:0] MAX_L = 18'(MAX_PULSE);
  localparam logic [SIL_W-1:0] TO_L  = SIL_W'(TIMEOUT);
  localparam logic [SIL_W-1:0] TO_M1 = SIL_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic             pwm_m, pwm_s, pwm_d;
  logic             rise_p0, fall_p0;
  logic [1:0]       settle;
  logic [17:0]      high_cnt;
  logic [21:0]      per_cnt;
  logic [SIL_W-1:0] sil_cnt;
  logic             take_ok, take_bad, enter_high, timeout_hit, in_range;

  function automatic logic [17:0] sat_inc18(input logic [17:0] v);
    return (&v) ? v : v + 18'd1;
  endfunction

  function automatic logic [21:0] sat_inc22(input logic [21:0] v);
    return (&v) ? v : v + 22'd1;
  endfunction

  assign in_range    = (high_cnt >= MIN_L) && (high_cnt <= MAX_L);
  assign timeout_hit = (sil_cnt == TO_M1) && !rise_p0;
  assign enter_high  = (state_nxt == HIGH) && (state != HIGH);

  // Edges are registered once more, so the FSM works in the pwm_d time frame:
  // rise_p0 coincides with the first cycle pwm_d is high, fall_p0 with the first low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_m   <= 1'b0;
      pwm_s   <= 1'b0;
      pwm_d   <= 1'b0;
      rise_p0 <= 1'b0;
      fall_p0 <= 1'b0;
      settle  <= 2'd0;
    end else begin
      pwm_m   <= pwm_in;
      pwm_s   <= pwm_m;
      pwm_d   <= pwm_s;
      rise_p0 <= pwm_s & ~pwm_d;
      fall_p0 <= ~pwm_s & pwm_d;
      if (settle != 2'd2) settle <= settle + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LOW;
    else        state <= state_nxt;
  end

  // The synchronizer must hold real samples before a low level can arm the
  // FSM, otherwise a pulse already high at reset release would look like a rise.
  always_comb begin
    state_nxt = state;
    take_ok   = 1'b0;
    take_bad  = 1'b0;
    case (state)
      WAIT_LOW:  if (settle == 2'd2 && !pwm_s && !pwm_d) state_nxt = WAIT_RISE;
      WAIT_RISE: if (rise_p0) state_nxt = HIGH;
      HIGH: begin
        if (fall_p0) begin
          state_nxt = LOW;
          take_ok   = in_range;
          take_bad  = !in_range;
        end
      end
      LOW:       if (rise_p0) state_nxt = HIGH;
      default:   state_nxt = WAIT_LOW;
    endcase
    if (timeout_hit) begin
      state_nxt = WAIT_LOW;
      take_ok   = 1'b0;
      take_bad  = 1'b0;
    end
  end

  // Measurement stage: counters, captured lengths and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt    <= '0;
      per_cnt     <= '0;
      sil_cnt     <= '0;
      pulse_len   <= '0;
      period_len  <= '0;
      valid       <= 1'b0;
      pulse_err   <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      if (enter_high) begin
        high_cnt <= 18'd1;
        per_cnt  <= 22'd1;
      end else begin
        if (state == HIGH && pwm_d)         high_cnt <= sat_inc18(high_cnt);
        if (state == HIGH || state == LOW) per_cnt  <= sat_inc22(per_cnt);
      end
      if (enter_high && state == LOW) period_len <= per_cnt;

      if (rise_p0)              sil_cnt <= '0;
      else if (sil_cnt != TO_L) sil_cnt <= sil_cnt + 1'b1;

      valid     <= take_ok;
      pulse_err <= take_bad;
      if (take_ok) pulse_len <= high_cnt;

      if (timeout_hit)  signal_lost <= 1'b1;
      else if (take_ok) signal_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture: table vectors, hand sequences for timeout/reset corners,
// and randomized pulse trains checked against a pulse-level behavioural model.
module tb_servo_pwm_capture;

  localparam int MINP = 50;
  localparam int MAXP = 250;
  localparam int TO   = 2500;

  logic        clk;
  logic        rst_n;
  logic        pwm_in;
  logic [17:0] pulse_len;
  logic [21:0] period_len;
  logic        valid;
  logic        pulse_err;
  logic        signal_lost;

  servo_pwm_capture #(.MIN_PULSE(MINP), .MAX_PULSE(MAXP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .pulse_len(pulse_len), .period_len(period_len),
    .valid(valid), .pulse_err(pulse_err), .signal_lost(signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Pulse-level model state
  bit m_armed;
  bit m_prev_rise;
  int m_last_per;
  int m_pulse;
  int m_period;
  bit m_lost;

  typedef struct {
    int h;
    int l;
    int exp_v;
    int exp_e;
    int exp_pulse;
    int exp_period;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset(input bit level);
    m_armed     = !level;
    m_prev_rise = 1'b0;
    m_last_per  = 0;
    m_pulse     = 0;
    m_period    = 0;
    m_lost      = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse_len"},  pulse_len,   0);
    check({tag, "_period_len"}, period_len,  0);
    check({tag, "_valid"},      valid,       0);
    check({tag, "_pulse_err"},  pulse_err,   0);
    check({tag, "_lost"},       signal_lost, 0);
  endtask

  // Drive h high cycles then l low cycles (called #1 after a posedge), watch the
  // strobes in the low phase and compare against the model.
  task automatic apply_pulse(input int h, input int l, input string tag,
                             output int nv, output int ne);
    int vo, eo, both, exp_v, exp_e;
    nv = 0; ne = 0; vo = 0; eo = 0; both = 0;
    pwm_in = 1'b1;
    repeat (h) @(posedge clk);
    #1 pwm_in = 1'b0;
    for (int k = 1; k <= l; k++) begin
      @(posedge clk);
      #1;
      if (valid)     begin nv++; vo = k; end
      if (pulse_err) begin ne++; eo = k; end
      if (valid && pulse_err) both++;
    end

    exp_v = 0;
    exp_e = 0;
    if (m_armed && m_prev_rise) m_period = m_last_per;
    if (m_armed && h <= TO) begin
      if (h >= MINP && h <= MAXP) begin
        exp_v   = 1;
        m_pulse = h;
        m_lost  = 1'b0;
      end else begin
        exp_e = 1;
      end
    end
    m_prev_rise = m_armed && (h + l <= TO);
    m_last_per  = h + l;
    if (h + l > TO) m_lost = 1'b1;
    m_armed = 1'b1;

    check({tag, "_valid_cnt"}, nv, exp_v);
    check({tag, "_err_cnt"},   ne, exp_e);
    if (exp_v != 0) check({tag, "_valid_lat"}, vo, 4);
    if (exp_e != 0) check({tag, "_err_lat"},   eo, 4);
    check({tag, "_both"},       both,        0);
    check({tag, "_pulse_len"},  pulse_len,   m_pulse);
    check({tag, "_period_len"}, period_len,  m_period);
    check({tag, "_lost"},       signal_lost, m_lost);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, ne, h, l;

    vecs[0] = '{150, 1850, 1, 0, 150, 0};
    vecs[1] = '{150, 1850, 1, 0, 150, 2000};
    vecs[2] = '{150, 1850, 1, 0, 150, 2000};
    vecs[3] = '{ 49,  200, 0, 1, 150, 2000};
    vecs[4] = '{ 50,  200, 1, 0,  50,  249};
    vecs[5] = '{250,  200, 1, 0, 250,  250};
    vecs[6] = '{251,  200, 0, 1, 250,  450};

    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    model_reset(1'b0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Nominal train and pulse-width boundaries
    for (int i = 0; i < 7; i++) begin
      apply_pulse(vecs[i].h, vecs[i].l, $sformatf("vec%0d", i), nv, ne);
      check($sformatf("vec%0d_tbl_valid", i),  nv,         vecs[i].exp_v);
      check($sformatf("vec%0d_tbl_err", i),    ne,         vecs[i].exp_e);
      check($sformatf("vec%0d_tbl_pulse", i),  pulse_len,  vecs[i].exp_pulse);
      check($sformatf("vec%0d_tbl_period", i), period_len, vecs[i].exp_period);
    end

    // Randomized pulse train, every gap well inside the timeout
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       h = $urandom_range(MINP - 3, MINP + 3);
        1:       h = $urandom_range(MAXP - 3, MAXP + 3);
        default: h = $urandom_range(20, 300);
      endcase
      l = $urandom_range(10, 400);
      apply_pulse(h, l, $sformatf("rnd%0d", i), nv, ne);
    end

    // Long silence after a legal pulse, then recovery
    apply_pulse(120, TO + 100, "silence", nv, ne);
    check("silence_lost_set", signal_lost, 1);
    apply_pulse(100, 300, "recover", nv, ne);
    check("recover_pulse", pulse_len, 100);
    check("recover_lost_clear", signal_lost, 0);

    // Input stuck high beyond the timeout
    apply_pulse(TO + 200, 100, "stuck_high", nv, ne);
    check("stuck_high_no_strobe", nv + ne, 0);
    apply_pulse(150, 300, "after_stuck", nv, ne);
    check("after_stuck_pulse", pulse_len, 150);

    // pulse_err must not clear signal_lost
    apply_pulse(80, TO + 100, "lost_again", nv, ne);
    apply_pulse(30, 300, "short_while_lost", nv, ne);
    check("err_keeps_lost", signal_lost, 1);
    apply_pulse(150, 300, "clear_lost", nv, ne);

    // Asynchronous reset 100 cycles into a pulse, released while still high
    pwm_in = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset(1'b1);
    apply_pulse(150, 200, "partial", nv, ne);
    check("partial_no_strobe", nv + ne, 0);
    apply_pulse(150, 300, "post_rst", nv, ne);
    check("post_rst_valid", nv, 1);
    check("post_rst_pulse", pulse_len, 150);
    apply_pulse(150, 300, "post_rst2", nv, ne);
    check("post_rst2_period", period_len, 450);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
